// File: rtl/fram_rd_arbiter_if.sv
// Bundles the requester-side and FRAM-side signals of the FRAM read arbiter.
// master: the arbiter itself; slave: the loaders and FRAM controller around it.
interface fram_rd_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_rden;
    logic [NUM_REQ*11-1:0] req_length;
    logic [NUM_REQ*16-1:0] req_addr;
    logic [NUM_REQ-1:0]    req_busy;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_last;
    logic [7:0]            req_data;
    logic [NUM_REQ-1:0]    req_err;
    logic                  fram_rden;
    logic [10:0]           fram_length;
    logic [15:0]           fram_addr;
    logic                  fram_valid;
    logic                  fram_last;
    logic [7:0]            fram_data;
    logic [ID_W-1:0]       active_id;

    modport master (
        input  req_rden, req_length, req_addr, fram_valid, fram_last, fram_data,
        output req_busy, req_valid, req_last, req_data, req_err,
        output fram_rden, fram_length, fram_addr, active_id
    );

    modport slave (
        output req_rden, req_length, req_addr, fram_valid, fram_last, fram_data,
        input  req_busy, req_valid, req_last, req_data, req_err,
        input  fram_rden, fram_length, fram_addr, active_id
    );
endinterface

// File: rtl/fram_rd_arbiter.sv
// Round-robin arbiter sharing one FRAM read-burst port between NUM_REQ loaders,
// with one pending request slot per loader and a stall timeout per burst.
module fram_rd_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned ID_W        = 2,
    parameter logic [19:0] TIMEOUT_CYC = 20'd1000000,
    parameter logic [10:0] MAX_LEN     = 11'd1024
) (
    input  logic               sys_clk,
    input  logic               glbl_rst,
    fram_rd_arbiter_if.master  bus
);

    typedef enum logic [1:0] {StIdle, StWait, StGap} state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   pend_q, pend_d;
    logic [NUM_REQ-1:0]   err_q, err_d;
    logic [NUM_REQ-1:0]   valid_q, valid_d;
    logic [NUM_REQ-1:0]   last_q, last_d;
    logic [15:0]          slot_addr_q [NUM_REQ];
    logic [15:0]          slot_addr_d [NUM_REQ];
    logic [10:0]          slot_len_q [NUM_REQ];
    logic [10:0]          slot_len_d [NUM_REQ];
    logic [ID_W-1:0]      last_grant_q, last_grant_d;
    logic [ID_W-1:0]      active_q, active_d;
    logic [19:0]          timer_q, timer_d;
    logic                 rden_q, rden_d;
    logic [15:0]          addr_q, addr_d;
    logic [10:0]          len_q, len_d;
    logic [7:0]           data_q, data_d;

    logic [NUM_REQ-1:0]   finish;
    logic                 found;
    logic [ID_W-1:0]      grant;

    always_comb begin
        int unsigned idx;
        state_d      = state_q;
        pend_d       = pend_q;
        err_d        = '0;
        valid_d      = '0;
        last_d       = '0;
        slot_addr_d  = slot_addr_q;
        slot_len_d   = slot_len_q;
        last_grant_d = last_grant_q;
        active_d     = active_q;
        timer_d      = timer_q;
        rden_d       = 1'b0;
        addr_d       = addr_q;
        len_d        = len_q;
        data_d       = data_q;
        finish       = '0;
        found        = 1'b0;
        grant        = '0;
        idx          = 0;

        unique case (state_q)
            StIdle: begin
                // Search starts just after the last owner so every pending slot gets a turn.
                for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                    idx = (32'(last_grant_q) + k) % NUM_REQ;
                    if (!found && pend_q[idx]) begin
                        found = 1'b1;
                        grant = ID_W'(idx);
                    end
                end
                if (found) begin
                    rden_d   = 1'b1;
                    addr_d   = slot_addr_q[grant];
                    len_d    = slot_len_q[grant];
                    active_d = grant;
                    timer_d  = '0;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (bus.fram_valid) begin
                    data_d            = bus.fram_data;
                    valid_d[active_q] = 1'b1;
                    last_d[active_q]  = bus.fram_last;
                    timer_d           = '0;
                    if (bus.fram_last) begin
                        finish[active_q] = 1'b1;
                        last_grant_d     = active_q;
                        state_d          = StGap;
                    end
                end else if (timer_q == TIMEOUT_CYC - 20'd1) begin
                    err_d[active_q]  = 1'b1;
                    finish[active_q] = 1'b1;
                    last_grant_d     = active_q;
                    state_d          = StGap;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + 20'd1;
                end
            end
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // A capture in the owner's completion cycle overrides the clear.
        for (int i = 0; i < NUM_REQ; i++) begin
            pend_d[i] = pend_q[i] & ~finish[i];
            if (bus.req_rden[i] && (!pend_q[i] || finish[i])) begin
                slot_addr_d[i] = bus.req_addr[16*i +: 16];
                slot_len_d[i]  = bus.req_length[11*i +: 11];
                if (bus.req_length[11*i +: 11] != 11'd0 &&
                    bus.req_length[11*i +: 11] <= MAX_LEN) begin
                    pend_d[i] = 1'b1;
                end else begin
                    err_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (glbl_rst) begin
            state_q      <= StIdle;
            pend_q       <= '0;
            err_q        <= '0;
            valid_q      <= '0;
            last_q       <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                slot_addr_q[i] <= '0;
                slot_len_q[i]  <= '0;
            end
            last_grant_q <= ID_W'(NUM_REQ - 1);
            active_q     <= '0;
            timer_q      <= '0;
            rden_q       <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            err_q        <= err_d;
            valid_q      <= valid_d;
            last_q       <= last_d;
            slot_addr_q  <= slot_addr_d;
            slot_len_q   <= slot_len_d;
            last_grant_q <= last_grant_d;
            active_q     <= active_d;
            timer_q      <= timer_d;
            rden_q       <= rden_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            data_q       <= data_d;
        end
    end

    assign bus.req_busy    = pend_q;
    assign bus.req_valid   = valid_q;
    assign bus.req_last    = last_q;
    assign bus.req_data    = data_q;
    assign bus.req_err     = err_q;
    assign bus.fram_rden   = rden_q;
    assign bus.fram_addr   = addr_q;
    assign bus.fram_length = len_q;
    assign bus.active_id   = active_q;

endmodule

// File: tb/tb_fram_rd_arbiter.sv
// Scoreboard bench for fram_rd_arbiter: directed stimulus pushes expected grants,
// bytes and error pulses; a negedge monitor pops and compares them as they appear.
module tb_fram_rd_arbiter;
    localparam int NR = 4;

    logic sys_clk = 1'b0;
    logic glbl_rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    fram_rd_arbiter_if #(.NUM_REQ(NR), .ID_W(2)) bus ();

    fram_rd_arbiter #(
        .NUM_REQ(NR),
        .ID_W(2),
        .TIMEOUT_CYC(20'd16),
        .MAX_LEN(11'd1024)
    ) dut (
        .sys_clk(sys_clk),
        .glbl_rst(glbl_rst),
        .bus(bus)
    );

    typedef struct { int id; logic [15:0] addr; logic [10:0] len; } grant_t;
    typedef struct { int id; logic [7:0] data; bit last; int cyc; } data_t;
    typedef struct { int id; bit tmo; int cyc; } err_t;

    grant_t exp_grant[$];
    data_t  exp_data[$];
    err_t   exp_err[$];
    bit     open_burst = 1'b0;

    function automatic void check(input string name, input logic [63:0] got,
                                  input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic void unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s got=event exp=none (cycle %0d)", name, cyc);
    endfunction

    // Monitor: every DUT output event must match the head of its queue.
    always @(negedge sys_clk) begin
        grant_t     g;
        data_t      d;
        err_t       r;
        logic [3:0] ev;
        if (glbl_rst) open_burst = 1'b0;
        if (bus.fram_rden) begin
            if (open_burst) unexpected("overlap");
            if (exp_grant.size() == 0) begin
                unexpected("grant");
            end else begin
                g = exp_grant.pop_front();
                check("grant", {bus.active_id, bus.fram_addr, bus.fram_length},
                      {2'(g.id), g.addr, g.len});
            end
            open_burst = 1'b1;
        end
        if (bus.req_valid != 4'h0 || bus.req_last != 4'h0) begin
            if (exp_data.size() == 0) begin
                unexpected("data");
            end else begin
                d  = exp_data.pop_front();
                ev = 4'b0001 << d.id;
                check("data", {bus.req_valid, bus.req_last, bus.req_data},
                      {ev, (d.last ? ev : 4'h0), d.data});
                check("data_lat", 64'(cyc), 64'(d.cyc));
            end
            if (bus.req_last != 4'h0) open_burst = 1'b0;
        end
        if (bus.req_err != 4'h0) begin
            if (exp_err.size() == 0) begin
                unexpected("err");
            end else begin
                r = exp_err.pop_front();
                check("err", 64'(bus.req_err), 64'(4'b0001 << r.id));
                check("err_lat", 64'(cyc), 64'(r.cyc));
                if (r.tmo) open_burst = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running exp=finished (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic set_slot(input int id, input logic [15:0] a, input logic [10:0] l);
        bus.req_addr[16*id +: 16]   = a;
        bus.req_length[11*id +: 11] = l;
    endtask

    task automatic push_grant(input int id, input logic [15:0] a, input logic [10:0] l);
        exp_grant.push_back('{id, a, l});
    endtask

    task automatic request(input logic [3:0] mask);
        logic [10:0] l;
        tick();
        bus.req_rden = mask;
        for (int i = 0; i < NR; i++) begin
            l = bus.req_length[11*i +: 11];
            if (mask[i] && (l == 11'd0 || l > 11'd1024)) exp_err.push_back('{i, 1'b0, cyc + 1});
        end
        tick();
        bus.req_rden = '0;
    endtask

    task automatic wait_rden(output int r);
        int n = 0;
        r = -1;
        while (r < 0 && n < 64) begin
            @(negedge sys_clk);
            n++;
            if (bus.fram_rden) r = cyc;
        end
        if (r < 0) unexpected("grant_wait_expired");
    endtask

    task automatic burst(input int id, input int n, input bit with_last,
                         input logic [7:0] seed, input logic [3:0] rden_on_last);
        logic [7:0] b;
        bit         l;
        tick();
        for (int i = 0; i < n; i++) begin
            b = seed + 8'(i * 7);
            l = with_last && (i == n - 1);
            bus.fram_valid = 1'b1;
            bus.fram_data  = b;
            bus.fram_last  = l;
            if (i == n - 1) bus.req_rden = rden_on_last;
            exp_data.push_back('{id, b, l, cyc + 1});
            tick();
        end
        bus.fram_valid = 1'b0;
        bus.fram_last  = 1'b0;
        bus.req_rden   = '0;
    endtask

    task automatic do_reset();
        glbl_rst = 1'b1;
        bus.fram_valid = 1'b0;
        bus.fram_last  = 1'b0;
        bus.req_rden   = '0;
        repeat (2) tick();
        glbl_rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  64'(bus.req_busy), 64'h0);
        check({tag, "_valid"}, 64'(bus.req_valid), 64'h0);
        check({tag, "_last"},  64'(bus.req_last), 64'h0);
        check({tag, "_err"},   64'(bus.req_err), 64'h0);
        check({tag, "_data"},  64'(bus.req_data), 64'h0);
        check({tag, "_rden"},  64'(bus.fram_rden), 64'h0);
        check({tag, "_addr"},  64'(bus.fram_addr), 64'h0);
        check({tag, "_len"},   64'(bus.fram_length), 64'h0);
        check({tag, "_id"},    64'(bus.active_id), 64'h0);
    endtask

    initial begin
        int r;
        bus.req_rden   = '0;
        bus.req_length = '0;
        bus.req_addr   = '0;
        bus.fram_valid = 1'b0;
        bus.fram_last  = 1'b0;
        bus.fram_data  = 8'h00;
        do_reset();
        @(negedge sys_clk);
        check_zero("reset");

        // Single 1024-byte burst for requester 0.
        set_slot(0, 16'h0400, 11'd1024);
        push_grant(0, 16'h0400, 11'd1024);
        request(4'b0001);
        wait_rden(r);
        check("single_busy", 64'(bus.req_busy), 64'h1);
        burst(0, 1024, 1'b1, 8'h10, 4'b0000);
        @(negedge sys_clk);
        check("single_busy_drop", 64'(bus.req_busy), 64'h0);

        // Contention from reset: 0,1,2,3 then 1,2.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            set_slot(i, 16'(16'h1000 * (i + 1)), 11'd4);
            push_grant(i, 16'(16'h1000 * (i + 1)), 11'd4);
        end
        request(4'b1111);
        for (int i = 0; i < NR; i++) begin
            wait_rden(r);
            burst(i, 4, 1'b1, 8'(8'h40 + 8'(i * 16)), 4'b0000);
        end
        set_slot(1, 16'h5100, 11'd4);
        set_slot(2, 16'h5200, 11'd5);
        push_grant(1, 16'h5100, 11'd4);
        push_grant(2, 16'h5200, 11'd5);
        request(4'b0110);
        wait_rden(r);
        burst(1, 4, 1'b1, 8'h81, 4'b0000);
        wait_rden(r);
        burst(2, 5, 1'b1, 8'h92, 4'b0000);

        // Fairness: 0 re-requests on its last byte while 2 waits.
        do_reset();
        set_slot(0, 16'h0A00, 11'd2);
        set_slot(2, 16'h0C00, 11'd3);
        push_grant(0, 16'h0A00, 11'd2);
        push_grant(2, 16'h0C00, 11'd3);
        push_grant(0, 16'h0B00, 11'd6);
        request(4'b0001);
        wait_rden(r);
        request(4'b0100);
        set_slot(0, 16'h0B00, 11'd6);
        burst(0, 2, 1'b1, 8'hA0, 4'b0001);
        @(negedge sys_clk);
        check("fair_busy", 64'(bus.req_busy), 64'h5);
        wait_rden(r);
        burst(2, 3, 1'b1, 8'hB0, 4'b0000);
        wait_rden(r);
        burst(0, 6, 1'b1, 8'hC0, 4'b0000);

        // Rejects: length 0 and 1025.
        set_slot(1, 16'h1111, 11'd0);
        request(4'b0010);
        set_slot(1, 16'h1111, 11'd1025);
        request(4'b0010);
        repeat (4) tick();
        check("reject_busy", 64'(bus.req_busy), 64'h0);

        // Timeout on requester 0, then 1 is served; a late byte is dropped.
        do_reset();
        set_slot(0, 16'h7000, 11'd8);
        set_slot(1, 16'h7100, 11'd4);
        push_grant(0, 16'h7000, 11'd8);
        push_grant(1, 16'h7100, 11'd4);
        request(4'b0011);
        wait_rden(r);
        exp_err.push_back('{0, 1'b1, r + 16});
        repeat (16) tick();
        bus.fram_valid = 1'b1;
        bus.fram_last  = 1'b1;
        bus.fram_data  = 8'hEE;
        @(negedge sys_clk);
        check("timeout_busy", 64'(bus.req_busy), 64'h2);
        tick();
        bus.fram_valid = 1'b0;
        bus.fram_last  = 1'b0;
        wait_rden(r);
        burst(1, 4, 1'b1, 8'hD0, 4'b0000);

        // Reset at byte 500 of 1024; remaining bytes must vanish.
        do_reset();
        set_slot(0, 16'h3000, 11'd1024);
        push_grant(0, 16'h3000, 11'd1024);
        request(4'b0001);
        wait_rden(r);
        burst(0, 500, 1'b0, 8'h21, 4'b0000);
        glbl_rst       = 1'b1;
        bus.fram_valid = 1'b1;
        bus.fram_data  = 8'h5A;
        tick();
        glbl_rst = 1'b0;
        @(negedge sys_clk);
        check_zero("midrst");
        for (int j = 502; j <= 1024; j++) begin
            bus.fram_valid = 1'b1;
            bus.fram_data  = 8'(j);
            bus.fram_last  = (j == 1024);
            tick();
        end
        bus.fram_valid = 1'b0;
        bus.fram_last  = 1'b0;
        set_slot(2, 16'h2222, 11'd3);
        push_grant(2, 16'h2222, 11'd3);
        request(4'b0100);
        wait_rden(r);
        burst(2, 3, 1'b1, 8'h33, 4'b0000);

        repeat (5) tick();
        check("grant_q_empty", 64'(exp_grant.size()), 64'h0);
        check("data_q_empty",  64'(exp_data.size()), 64'h0);
        check("err_q_empty",   64'(exp_err.size()), 64'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fram_rd_arbiter.md
Name: fram_rd_arbiter

Overview:
- Shares the single FRAM read-request port (rden/length/addr in, valid/last/data out) between NUM_REQ loader blocks, e.g. the A-FPGA and other image loaders.
- Latches one pending request per requester and grants round-robin.
- Issues exactly one FRAM burst at a time, routes the returned byte stream to the owner, and aborts stalled bursts on timeout.
- Sits between the initialisation loaders and the FRAM controller in the PFPGA.

Parameters:
- NUM_REQ, 4, number of requesters (2..4).
- ID_W, 2, width of the requester index; clog2(NUM_REQ), minimum 1.
- TIMEOUT_CYC, 20'd1000000, sys_clk cycles without fram_valid in WAIT before the burst is aborted.
- MAX_LEN, 11'd1024, largest legal burst length in bytes.

Ports:
- sys_clk  in  1  single clock for the whole block.
- glbl_rst  in  1  synchronous, active-high reset.
- req_rden  in  NUM_REQ  one-cycle request strobe per requester.
- req_length  in  NUM_REQ*11  burst length; requester i uses bits [11i+10:11i].
- req_addr  in  NUM_REQ*16  FRAM start address; requester i uses bits [16i+15:16i].
- req_busy  out  NUM_REQ  request pending or in service.
- req_valid  out  NUM_REQ  data strobe to the owning requester.
- req_last  out  NUM_REQ  last-byte strobe to the owning requester.
- req_data  out  8  returned byte, shared by all requesters.
- req_err  out  NUM_REQ  one-cycle pulse on reject or timeout.
- fram_rden  out  1  one-cycle burst start to the FRAM controller.
- fram_length  out  11  burst length.
- fram_addr  out  16  burst start address.
- fram_valid  in  1  returned byte valid.
- fram_last  in  1  final byte of the burst; qualified by fram_valid.
- fram_data  in  8  returned byte.
- active_id  out  ID_W  index of the requester currently granted.

Behaviour:
- Reset (sys_clk edge with glbl_rst=1) takes priority over everything:
  - all outputs are 0;
  - pend, last_grant (=NUM_REQ-1) and the timer are cleared;
  - state goes to IDLE.
  - FRAM bytes arriving after reset in IDLE are discarded. Reset mid-burst needs no special handling.
- Capture, evaluated per requester i:
  - If req_rden[i]=1 and (pend[i]=0 or requester i completes this cycle), latch addr/length into slot i.
  - Set pend[i] only if 1 <= length <= MAX_LEN.
  - Otherwise pend[i] stays 0 and req_err[i] pulses on the next cycle.
  - req_rden[i] while pend[i]=1 and not completing is ignored silently.
- req_busy = pend, registered.
- FSM states: IDLE, WAIT, GAP.
  - IDLE: if any pend bit is set, grant the first set bit searching from last_grant+1 with wrap-around. On that edge register fram_rden=1, fram_addr/fram_length from the slot, active_id=grant, clear the timer, go to WAIT.
  - IDLE latency: req_rden sampled at edge T, pend visible after T, fram_rden high for the cycle after edge T+1.
  - WAIT: fram_rden returns to 0 after one cycle. fram_addr and fram_length hold until IDLE.
  - WAIT data path: on fram_valid, register req_data=fram_data, req_valid[active_id]=1, req_last[active_id]=fram_last, reset the timer. One cycle latency; the other bits stay 0.
  - WAIT completion: on fram_valid&&fram_last, clear pend[active_id], set last_grant=active_id, go to GAP.
  - WAIT timeout: if no fram_valid, increment the timer. At TIMEOUT_CYC-1, pulse req_err[active_id], clear pend[active_id], set last_grant=active_id, go to GAP.
  - GAP: one cycle, then IDLE. fram_valid in GAP or IDLE is dropped.
- The length count is not checked against the number of valid bytes; fram_last alone ends a burst.
- A new capture and a completion for the same requester in the same cycle leave pend[i]=1 (capture wins).
- A requester re-requesting immediately is still served round-robin behind the other pending requesters.
- Timer is 20 bits and saturates; it never wraps.

Test Plan:
- Single request: req_rden[0] with addr 16'h0400, len 1024; feed 1024 bytes, last on byte 1024. Required: one fram_rden pulse with addr 0x0400 / len 1024; 1024 req_valid[0] strobes with data one cycle delayed; req_last[0] on the final byte; req_busy[0] drops; no activity on requesters 1-3.
- Contention: req_rden[0..3] in the same cycle, 4-byte bursts each. Required: grant order 0,1,2,3 with exactly one burst outstanding at a time. A further req 1 and req 2 after that order are served 1 then 2.
- Fairness: requester 0 re-requests in its own completion cycle while requester 2 is pending. Required: busy[0] stays 1 and requester 2 is served before 0.
- Reject: len 0, then len 1025. Required: req_err pulses once for each, no fram_rden, busy stays 0.
- Timeout with TIMEOUT_CYC=16: grant, then no fram_valid. Required: req_err[active_id] pulse on the 16th WAIT cycle, pend cleared, next requester granted; late bytes are dropped.
- Reset mid-burst (byte 500 of 1024): required: all outputs 0 on the next cycle, remaining bytes produce no req_valid, and a new request afterwards works normally.
